// File: rtl/pe_acc_requant_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc_requant_pkg
// Description : Widths, Q-format constants and types shared by the PE
//               accumulate/requantise stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pe_acc_requant_pkg;

    localparam int A        = 8;
    localparam int B        = 8;
    localparam int O        = A + B + 2;
    localparam int IN_FRAC  = 8;
    localparam int OUT_W    = 8;
    localparam int OUT_FRAC = 4;
    localparam int MAX_PASS = 16;
    localparam int ACC_W    = O + $clog2(MAX_PASS);

    localparam logic [OUT_W-1:0] OUT_MAX = 8'h7F;
    localparam logic [OUT_W-1:0] OUT_MIN = 8'h80;

    typedef logic signed [O-1:0]     pe_sum_t;
    typedef logic signed [OUT_W-1:0] q44_t;
    typedef logic signed [ACC_W-1:0] acc_t;

    function automatic acc_t sext_sum(input pe_sum_t s);
        return {{(ACC_W - O){s[O-1]}}, s};
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_acc_requant_if.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc_requant_if
// Description : PE-sum input stream and Q4.4 result stream of the
//               accumulate/requantise stage. Names are from the stage's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pe_acc_requant_if;
    import pe_acc_requant_pkg::*;

    logic    i_pe_valid;
    logic    o_pe_ready;
    pe_sum_t i_pe_sum;
    logic    i_pe_last;
    logic    o_out_valid;
    logic    i_out_ready;
    q44_t    o_out_data;
    logic    o_out_sat;

    modport master (
        output i_pe_valid, i_pe_sum, i_pe_last, i_out_ready,
        input  o_pe_ready, o_out_valid, o_out_data, o_out_sat
    );

    modport slave (
        input  i_pe_valid, i_pe_sum, i_pe_last, i_out_ready,
        output o_pe_ready, o_out_valid, o_out_data, o_out_sat
    );

endinterface
`default_nettype wire

// File: rtl/fxp_round_sat.sv
`default_nettype none
// ============================================================================
// Module      : fxp_round_sat
// Description : Combinational round-half-up right shift, optional ReLU and
//               signed saturation to a narrow fixed-point result.
// Revision    : 1.0 - initial release
// ============================================================================
module fxp_round_sat
    import pe_acc_requant_pkg::*;
#(
    parameter int IN_W  = ACC_W,
    parameter int SH    = IN_FRAC - OUT_FRAC,
    parameter int RES_W = OUT_W
) (
    input  wire logic signed [IN_W-1:0]  i_total,
    input  wire logic                    i_relu_en,
    output logic signed      [RES_W-1:0] o_data,
    output logic                         o_sat
);

    // One guard bit so the rounding constant can never wrap the top value.
    localparam int c_W = IN_W + 1;
    localparam logic signed [c_W-1:0] c_HALF = c_W'(2 ** (SH - 1));
    localparam logic signed [c_W-1:0] c_MAX  = c_W'(2 ** (RES_W - 1) - 1);
    localparam logic signed [c_W-1:0] c_MIN  = c_W'(-(2 ** (RES_W - 1)));

    logic signed [c_W-1:0] w_ext;
    logic signed [c_W-1:0] w_rnd;
    logic signed [c_W-1:0] w_shr;
    logic signed [c_W-1:0] w_relu;

    always_comb begin
        w_ext  = {i_total[IN_W-1], i_total};
        w_rnd  = w_ext + c_HALF;
        w_shr  = w_rnd >>> SH;
        // ReLU clamps before saturation, so a clamped value never reports sat.
        w_relu = (i_relu_en && w_shr[c_W-1]) ? '0 : w_shr;
        o_data = w_relu[RES_W-1:0];
        o_sat  = 1'b0;
        if (w_relu > c_MAX) begin
            o_data = c_MAX[RES_W-1:0];
            o_sat  = 1'b1;
        end else if (w_relu < c_MIN) begin
            o_data = c_MIN[RES_W-1:0];
            o_sat  = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pe_acc_requant.sv
`default_nettype none
// ============================================================================
// Module      : pe_acc_requant
// Description : Accumulates PE dot-product beats per group and emits the
//               rounded, saturated Q4.4 result on a valid/ready output.
// Revision    : 1.0 - initial release
// ============================================================================
module pe_acc_requant
    import pe_acc_requant_pkg::*;
(
    input  wire logic       i_clk,
    input  wire logic       i_reset,
    input  wire logic       i_relu_en,
    output logic            o_acc_ovf,
    pe_acc_requant_if.slave bus
);

    // One spare bit lets the counter pass MAX_PASS-1 without wrapping to idle.
    localparam int                 c_CNT_W    = $clog2(MAX_PASS) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(MAX_PASS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = '1;

    acc_t               r_acc;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic               r_out_valid;
    q44_t               r_out_data;
    logic               r_out_sat;
    logic               r_acc_ovf;

    logic               w_pe_ready;
    logic               w_accept;
    logic               w_drain;
    acc_t               w_total;
    q44_t               w_q;
    logic               w_sat;

    // A blocked output stalls every beat, not just the closing one.
    assign w_pe_ready = !(r_out_valid && !bus.i_out_ready);
    assign w_accept   = bus.i_pe_valid && w_pe_ready;
    assign w_drain    = r_out_valid && bus.i_out_ready;
    assign w_total    = r_acc + sext_sum(bus.i_pe_sum);

    fxp_round_sat #(
        .IN_W  (ACC_W),
        .SH    (IN_FRAC - OUT_FRAC),
        .RES_W (OUT_W)
    ) u_round_sat (
        .i_total   (w_total),
        .i_relu_en (i_relu_en),
        .o_data    (w_q),
        .o_sat     (w_sat)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc       <= '0;
            r_beat_cnt  <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_acc_ovf   <= 1'b0;
        end else begin
            if (w_drain) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                if (bus.i_pe_last) begin
                    // Load overrides a same-cycle drain, keeping valid high.
                    r_out_valid <= 1'b1;
                    r_out_data  <= w_q;
                    r_out_sat   <= w_sat;
                    r_acc       <= '0;
                    r_beat_cnt  <= '0;
                end else begin
                    r_acc <= w_total;
                    if (r_beat_cnt != c_CNT_MAX) begin
                        r_beat_cnt <= r_beat_cnt + c_CNT_W'(1);
                    end
                    if (r_beat_cnt == c_LAST_CNT) begin
                        r_acc_ovf <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_pe_ready  = w_pe_ready;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_out_data  = r_out_data;
    assign bus.o_out_sat   = r_out_sat;
    assign o_acc_ovf       = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pe_acc_requant.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_acc_requant
// Description : Self-checking bench for pe_acc_requant: vector table, random
//               groups, backpressure and overflow/reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_acc_requant;
    import pe_acc_requant_pkg::*;

    typedef struct {
        logic [7:0] data;
        logic       sat;
    } exp_t;

    typedef struct {
        int                  n;
        logic [3:0][O-1:0]   sums;
        logic                relu;
        logic [7:0]          data;
        logic                sat;
    } vec_t;

    localparam int NV = 15;

    logic clk = 1'b0;
    logic rst;
    logic relu_en;
    logic acc_ovf;
    int   checks;
    int   failures;
    exp_t sb [$];
    vec_t vecs [NV];

    pe_acc_requant_if bus ();

    pe_acc_requant u_dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_relu_en (relu_en),
        .o_acc_ovf (acc_ovf),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [O-1:0] s0, input logic [O-1:0] s1,
                                input logic [O-1:0] s2, input logic [O-1:0] s3,
                                input logic relu, input logic [7:0] d, input logic s);
        vec_t v;
        v.n       = n;
        v.sums[0] = s0;
        v.sums[1] = s1;
        v.sums[2] = s2;
        v.sums[3] = s3;
        v.relu    = relu;
        v.data    = d;
        v.sat     = s;
        return v;
    endfunction

    // Reference requantiser on plain integers.
    function automatic exp_t model(input longint total, input logic relu);
        longint r;
        exp_t   e;
        r = (total + 8) >>> 4;
        if (relu && r < 0) r = 0;
        if (r > 127) begin
            e.data = 8'h7F; e.sat = 1'b1;
        end else if (r < -128) begin
            e.data = 8'h80; e.sat = 1'b1;
        end else begin
            e.data = r[7:0]; e.sat = 1'b0;
        end
        return e;
    endfunction

    task automatic monitor();
        logic [7:0] held_data;
        logic       held_sat;
        bit         holding;
        exp_t       e;
        holding = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                holding = 1'b0;
            end else begin
                if (holding && bus.o_out_valid) begin
                    check("hold_data", {24'h0, unsigned'(bus.o_out_data)}, {24'h0, held_data});
                    check("hold_sat", {31'h0, bus.o_out_sat}, {31'h0, held_sat});
                end
                holding   = bus.o_out_valid && !bus.i_out_ready;
                held_data = bus.o_out_data;
                held_sat  = bus.o_out_sat;
                if (bus.o_out_valid && bus.i_out_ready) begin
                    if (sb.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out: got 0x%0h expected no result", bus.o_out_data);
                    end else begin
                        e = sb.pop_front();
                        check("out_data", {24'h0, unsigned'(bus.o_out_data)}, {24'h0, e.data});
                        check("out_sat", {31'h0, bus.o_out_sat}, {31'h0, e.sat});
                    end
                end
            end
        end
    endtask

    task automatic send_beat(input logic [O-1:0] sum, input logic last);
        bit accepted;
        int waited;
        waited         = 0;
        bus.i_pe_valid = 1'b1;
        bus.i_pe_sum   = sum;
        bus.i_pe_last  = last;
        forever begin
            @(negedge clk);
            accepted = bus.o_pe_ready;
            @(posedge clk);
            #1;
            if (accepted) break;
            waited++;
            if (waited >= 50) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout: got ready=0 for %0d cycles expected ready=1", waited);
                break;
            end
        end
        bus.i_pe_valid = 1'b0;
        bus.i_pe_last  = 1'b0;
        if (accepted && last) check("latency_valid", {31'h0, bus.o_out_valid}, 32'h1);
    endtask

    task automatic send_group(input vec_t v);
        exp_t e;
        relu_en = v.relu;
        e.data  = v.data;
        e.sat   = v.sat;
        sb.push_back(e);
        for (int b = 0; b < v.n; b++) send_beat(v.sums[b], (b == v.n - 1));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus.o_out_valid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 200) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        relu_en  = 1'b0;
        bus.i_pe_valid  = 1'b0;
        bus.i_pe_sum    = '0;
        bus.i_pe_last   = 1'b0;
        bus.i_out_ready = 1'b1;

        vecs[0]  = mk(1, 18'h01FB0, 18'h0, 18'h0, 18'h0, 1'b0, 8'h7F, 1'b1);
        vecs[1]  = mk(2, 18'h00180, 18'h00048, 18'h0, 18'h0, 1'b0, 8'h1D, 1'b0);
        vecs[2]  = mk(1, 18'h3FE00, 18'h0, 18'h0, 18'h0, 1'b0, 8'hE0, 1'b0);
        vecs[3]  = mk(1, 18'h3FE00, 18'h0, 18'h0, 18'h0, 1'b1, 8'h00, 1'b0);
        vecs[4]  = mk(1, 18'h3F600, 18'h0, 18'h0, 18'h0, 1'b0, 8'h80, 1'b1);
        vecs[5]  = mk(1, 18'h3FFF8, 18'h0, 18'h0, 18'h0, 1'b0, 8'h00, 1'b0);
        vecs[6]  = mk(1, 18'h3FFF7, 18'h0, 18'h0, 18'h0, 1'b0, 8'hFF, 1'b0);
        vecs[7]  = mk(1, 18'h007F7, 18'h0, 18'h0, 18'h0, 1'b0, 8'h7F, 1'b0);
        vecs[8]  = mk(1, 18'h007F8, 18'h0, 18'h0, 18'h0, 1'b0, 8'h7F, 1'b1);
        vecs[9]  = mk(1, 18'h3F7F8, 18'h0, 18'h0, 18'h0, 1'b0, 8'h80, 1'b0);
        vecs[10] = mk(1, 18'h3F7F7, 18'h0, 18'h0, 18'h0, 1'b0, 8'h80, 1'b1);
        vecs[11] = mk(1, 18'h00100, 18'h0, 18'h0, 18'h0, 1'b1, 8'h10, 1'b0);
        vecs[12] = mk(3, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 18'h0, 1'b0, 8'h7F, 1'b1);
        vecs[13] = mk(4, 18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b1, 8'h00, 1'b0);
        vecs[14] = mk(4, 18'h20000, 18'h20000, 18'h20000, 18'h20000, 1'b0, 8'h80, 1'b1);

        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", {31'h0, bus.o_out_valid}, 32'h0);
        check("rst_out_data", {24'h0, unsigned'(bus.o_out_data)}, 32'h0);
        check("rst_out_sat", {31'h0, bus.o_out_sat}, 32'h0);
        check("rst_acc_ovf", {31'h0, acc_ovf}, 32'h0);
        check("rst_pe_ready", {31'h0, bus.o_pe_ready}, 32'h1);
        rst = 1'b0;

        // Back-to-back groups: each load coincides with the previous drain.
        for (int i = 0; i < NV; i++) send_group(vecs[i]);

        for (int g = 0; g < 8; g++) begin
            vec_t    v;
            exp_t    e;
            longint  tot;
            pe_sum_t t;
            v.n    = int'($urandom_range(1, 4));
            v.relu = 1'($urandom_range(0, 1));
            tot    = 0;
            for (int b = 0; b < 4; b++) begin
                v.sums[b] = O'(int'($urandom_range(0, 3000)) - 1500);
                t = v.sums[b];
                if (b < v.n) tot += t;
            end
            e      = model(tot, v.relu);
            v.data = e.data;
            v.sat  = e.sat;
            send_group(v);
        end
        wait_drain();

        // Backpressure: a blocked result stalls the next group's beats.
        relu_en = 1'b0;
        bus.i_out_ready = 1'b0;
        send_group(mk(1, 18'h00100, 18'h0, 18'h0, 18'h0, 1'b0, 8'h10, 1'b0));
        bus.i_pe_valid = 1'b1;
        bus.i_pe_sum   = 18'h00200;
        bus.i_pe_last  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_pe_ready", {31'h0, bus.o_pe_ready}, 32'h0);
            check("bp_out_data", {24'h0, unsigned'(bus.o_out_data)}, 32'h10);
        end
        @(posedge clk);
        #1;
        bus.i_out_ready = 1'b1;
        begin
            exp_t e;
            e.data = 8'h24;
            e.sat  = 1'b0;
            sb.push_back(e);
        end
        send_beat(18'h00200, 1'b0);
        send_beat(18'h00040, 1'b1);
        wait_drain();

        // Overflow flag, then reset mid-group discards the partial sum.
        for (int k = 1; k <= 17; k++) begin
            send_beat(18'h00100, 1'b0);
            if (k == 15) check("ovf_before", {31'h0, acc_ovf}, 32'h0);
            if (k == 16) check("ovf_set", {31'h0, acc_ovf}, 32'h1);
        end
        check("ovf_sticky", {31'h0, acc_ovf}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_ovf", {31'h0, acc_ovf}, 32'h0);
        check("mid_rst_valid", {31'h0, bus.o_out_valid}, 32'h0);
        check("mid_rst_data", {24'h0, unsigned'(bus.o_out_data)}, 32'h0);
        check("mid_rst_sat", {31'h0, bus.o_out_sat}, 32'h0);
        rst = 1'b0;
        send_group(mk(1, 18'h00100, 18'h0, 18'h0, 18'h0, 1'b0, 8'h10, 1'b0));
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
